// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU operand issuer: op codes, flag bit positions,
// issuer FSM states and the command/response payload structs.
package fpu_pkg;

    localparam int unsigned OP_W   = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned FLAG_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_MUL = 2'b10;
    localparam logic [OP_W-1:0] OP_DIV = 2'b11;

    // Bit positions inside the 3-bit flag vectors.
    localparam int unsigned FLG_ERR = 2;
    localparam int unsigned FLG_OVF = 1;
    localparam int unsigned FLG_UDF = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Operands launched towards the FPU.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } fpu_cmd_t;

    // Sampled FPU outcome.
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [FLAG_W-1:0] flags;
    } fpu_rsp_t;

    // Assemble the individual FPU status bits into the flag vector order.
    function automatic logic [FLAG_W-1:0] pack_flags(input logic err,
                                                     input logic ovf,
                                                     input logic udf);
        logic [FLAG_W-1:0] f;
        f          = '0;
        f[FLG_ERR] = err;
        f[FLG_OVF] = ovf;
        f[FLG_UDF] = udf;
        return f;
    endfunction

endpackage

// File: rtl/fpu_op_issuer.sv
// fpu_op_issuer: initiator for a combinational FPU.
// Accepts one command on cmd_valid/cmd_ready, launches op/a/b on registered
// fpu_* outputs, waits SETTLE_CYCLES, samples result and status, and returns
// them on rsp_valid/rsp_ready. Keeps sticky flags and a wrapping op counter.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_op/a/b    command port (cmd_ready is combinational)
//   fpu_op/fpu_a/fpu_b                registered operands to the FPU
//   fpu_result/error/overflow/underflow  FPU outputs
//   rsp_valid/rsp_ready/rsp_result/rsp_flags  response port
//   sticky_flags/sticky_clr           accumulated flags and their clear
//   op_count                          completed captures, wraps
//   busy                              high outside IDLE
module fpu_op_issuer
    import fpu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OP_W-1:0]     cmd_op,
    input  logic [DATA_W-1:0]   cmd_a,
    input  logic [DATA_W-1:0]   cmd_b,
    output logic [OP_W-1:0]     fpu_op,
    output logic [DATA_W-1:0]   fpu_a,
    output logic [DATA_W-1:0]   fpu_b,
    input  logic [DATA_W-1:0]   fpu_result,
    input  logic                fpu_error,
    input  logic                fpu_overflow,
    input  logic                fpu_underflow,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_result,
    output logic [FLAG_W-1:0]   rsp_flags,
    output logic [FLAG_W-1:0]   sticky_flags,
    input  logic                sticky_clr,
    output logic [CNT_W-1:0]    op_count,
    output logic                busy
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);

    // A zero settle time would sample in the launch cycle; refuse it.
    if (SETTLE_CYCLES < 1) begin : g_settle_check
        $error("fpu_op_issuer: SETTLE_CYCLES must be >= 1");
    end

    state_e              state_q,     state_d;
    logic [SET_W-1:0]    settle_q,    settle_d;
    fpu_cmd_t            cmd_q,       cmd_d;
    fpu_rsp_t            rsp_q,       rsp_d;
    logic [FLAG_W-1:0]   sticky_q,    sticky_d;
    logic [CNT_W-1:0]    count_q,     count_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                busy_q,      busy_d;

    logic [FLAG_W-1:0]   fpu_flags;

    assign fpu_flags = pack_flags(fpu_error, fpu_overflow, fpu_underflow);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            cmd_q       <= '0;
            rsp_q       <= '0;
            sticky_q    <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            cmd_q       <= cmd_d;
            rsp_q       <= rsp_d;
            sticky_q    <= sticky_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, datapath updates and the command-ready strobe.
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        cmd_d     = cmd_q;
        rsp_d     = rsp_q;
        sticky_d  = sticky_q;
        count_d   = count_q;
        cmd_ready = 1'b0;

        // Clear is applied before any same-edge capture so new flags survive.
        if (sticky_clr) begin
            sticky_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cmd_d.op = cmd_op;
                    cmd_d.a  = cmd_a;
                    cmd_d.b  = cmd_b;
                    settle_d = SET_LOAD;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (settle_q == '0) begin
                    rsp_d.result = fpu_result;
                    rsp_d.flags  = fpu_flags;
                    sticky_d     = sticky_d | fpu_flags;
                    count_d      = count_q + CNT_W'(1);
                    state_d      = RESP;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    assign fpu_op       = cmd_q.op;
    assign fpu_a        = cmd_q.a;
    assign fpu_b        = cmd_q.b;
    assign rsp_result   = rsp_q.result;
    assign rsp_flags    = rsp_q.flags;
    assign sticky_flags = sticky_q;
    assign op_count     = count_q;
    assign rsp_valid    = rsp_valid_q;
    assign busy         = busy_q;

endmodule
